// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the p4Cpu datapath
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB one instruction at a time, drives the
//   datapath enables and the IFU next-PC select, and handshakes with imem/dmem.
// Parameters: WAIT_LIMIT (ack wait cycles before TRAP, 0 = unlimited),
//   CNT_W (counter width, only with MCTRL_PERF_CNT_EN).
// Ports: clk; reset (async, active-low); opcode/funct (IR fields); imem_ack/dmem_ack;
//   imem_req, ir_we, pc_we, PCsel, reg_we, reg_dst, wd_sel, alu_src, ext_op, alu_op,
//   mem_re, mem_we, trap (sticky), state (debug); cyc_cnt/ret_cnt (optional).
// Option macro: MCTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16
`ifdef MCTRL_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] PCsel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic       mem_re,
    output logic       mem_we,
    output logic       trap,
    output logic [2:0] state
`ifdef MCTRL_PERF_CNT_EN
    , output logic [CNT_W-1:0] cyc_cnt
    , output logic [CNT_W-1:0] ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        I_ILL, I_NOP, I_JR, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
    } instr_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // The counter never has to hold more than WAIT_LIMIT-1: the next miss traps.
    localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

    state_t         state_q, state_nx;
    instr_t         instr;
    logic [WCW-1:0] wait_cnt;
    logic           waiting, timeout;

    logic       ex_alu_src;
    logic [1:0] ex_ext_op;
    logic [2:0] ex_alu_op;

    logic       imem_req_c, ir_we_c, pc_we_c, reg_we_c, alu_src_c, mem_re_c, mem_we_c, trap_c;
    logic [1:0] pcsel_c, reg_dst_c, wd_sel_c, ext_op_c;
    logic [2:0] alu_op_c;

    always_comb begin
        instr = I_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_NOP:  instr = I_NOP;
                    FN_JR:   instr = I_JR;
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
                    default: instr = I_ILL;
                endcase
            end
            OP_J:    instr = I_J;
            OP_JAL:  instr = I_JAL;
            OP_BEQ:  instr = I_BEQ;
            OP_ORI:  instr = I_ORI;
            OP_LUI:  instr = I_LUI;
            OP_LW:   instr = I_LW;
            OP_SW:   instr = I_SW;
            default: instr = I_ILL;
        endcase
    end

    // ALU setup for the current instruction; presented from EXEC until it retires.
    always_comb begin
        ex_alu_src = 1'b0;
        ex_ext_op  = 2'b00;
        ex_alu_op  = 3'b000;
        case (instr)
            I_SUBU, I_BEQ: ex_alu_op = 3'b001;
            I_ORI: begin
                ex_alu_op  = 3'b010;
                ex_alu_src = 1'b1;
            end
            I_LUI: begin
                ex_alu_op  = 3'b011;
                ex_alu_src = 1'b1;
                ex_ext_op  = 2'b10;
            end
            I_LW, I_SW: begin
                ex_alu_src = 1'b1;
                ex_ext_op  = 2'b01;
            end
            default: ;
        endcase
    end

    assign waiting = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
    // Only a miss on the last allowed cycle traps; an ack that cycle proceeds.
    assign timeout = (WAIT_LIMIT != 0) && (wait_cnt == WCW'(WAIT_LIMIT - 1));

    always_comb begin
        state_nx   = state_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pcsel_c    = 2'b00;
        reg_we_c   = 1'b0;
        reg_dst_c  = 2'b00;
        wd_sel_c   = 2'b00;
        alu_src_c  = 1'b0;
        ext_op_c   = 2'b00;
        alu_op_c   = 3'b000;
        mem_re_c   = 1'b0;
        mem_we_c   = 1'b0;
        trap_c     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_we_c  = 1'b1;
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                end
            end
            S_DECODE: begin
                case (instr)
                    I_J: begin
                        pc_we_c  = 1'b1;
                        pcsel_c  = 2'b10;
                        state_nx = S_FETCH;
                    end
                    I_JR: begin
                        pc_we_c  = 1'b1;
                        pcsel_c  = 2'b11;
                        state_nx = S_FETCH;
                    end
                    I_NOP: begin
                        pc_we_c  = 1'b1;
                        state_nx = S_FETCH;
                    end
                    I_JAL:   state_nx = S_WB;
                    I_ILL:   state_nx = S_TRAP;
                    default: state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_src_c = ex_alu_src;
                ext_op_c  = ex_ext_op;
                alu_op_c  = ex_alu_op;
                if (instr == I_BEQ) begin
                    pc_we_c  = 1'b1;
                    pcsel_c  = 2'b01;
                    state_nx = S_FETCH;
                end else if (instr == I_LW || instr == I_SW) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                alu_src_c = ex_alu_src;
                ext_op_c  = ex_ext_op;
                alu_op_c  = ex_alu_op;
                mem_re_c  = (instr == I_LW);
                mem_we_c  = (instr == I_SW);
                if (dmem_ack) begin
                    if (instr == I_LW) begin
                        state_nx = S_WB;
                    end else begin
                        pc_we_c  = 1'b1;
                        state_nx = S_FETCH;
                    end
                end else if (timeout) begin
                    state_nx = S_TRAP;
                end
            end
            S_WB: begin
                alu_src_c = ex_alu_src;
                ext_op_c  = ex_ext_op;
                alu_op_c  = ex_alu_op;
                reg_we_c  = 1'b1;
                pc_we_c   = 1'b1;
                state_nx  = S_FETCH;
                case (instr)
                    I_ADDU, I_SUBU: reg_dst_c = 2'b01;
                    I_LW:           wd_sel_c  = 2'b01;
                    I_JAL: begin
                        reg_dst_c = 2'b10;
                        wd_sel_c  = 2'b10;
                        pcsel_c   = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_TRAP: trap_c = 1'b1;
            default: state_nx = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_nx;
            if (state_nx != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end
        end
    end

    // Gate with reset so no enable can pulse while reset is held.
    assign imem_req = reset & imem_req_c;
    assign ir_we    = reset & ir_we_c;
    assign pc_we    = reset & pc_we_c;
    assign PCsel    = reset ? pcsel_c : 2'b00;
    assign reg_we   = reset & reg_we_c;
    assign reg_dst  = reset ? reg_dst_c : 2'b00;
    assign wd_sel   = reset ? wd_sel_c : 2'b00;
    assign alu_src  = reset & alu_src_c;
    assign ext_op   = reset ? ext_op_c : 2'b00;
    assign alu_op   = reset ? alu_op_c : 3'b000;
    assign mem_re   = reset & mem_re_c;
    assign mem_we   = reset & mem_we_c;
    assign trap     = reset & trap_c;
    assign state    = state_q;

`ifdef MCTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state_q != S_TRAP) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (pc_we_c) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int WAIT_LIMIT = 16;
`ifdef MCTRL_PERF_CNT_EN
    localparam int CNT_W = 4;
`endif

    localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_NOP = 10;
    localparam int C_ILL_OP = 11, C_ILL_FN = 12;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcs;
        logic       rwe;
        logic [1:0] rd;
        logic [1:0] wd;
        logic [5:0] alu;
        logic       mre;
        logic       mwe;
        logic       tr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       imem_ack, dmem_ack;
    logic       imem_req, ir_we, pc_we, reg_we, alu_src, mem_re, mem_we, trap;
    logic [1:0] PCsel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op, state;
`ifdef MCTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;
`endif

    vec_t obs;
    assign obs = {state, imem_req, ir_we, pc_we, PCsel, reg_we, reg_dst, wd_sel,
                  alu_src, ext_op, alu_op, mem_re, mem_we, trap};

    int checks = 0;
    int failures = 0;
    int m_cyc = 0;
    int m_ret = 0;

    multicycle_ctrl #(
        .WAIT_LIMIT(WAIT_LIMIT)
`ifdef MCTRL_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
        .pc_we(pc_we), .PCsel(PCsel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .mem_re(mem_re),
        .mem_we(mem_we), .trap(trap), .state(state)
`ifdef MCTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic vec_t at(input logic [2:0] st);
        vec_t v;
        v = '0;
        v.st = st;
        return v;
    endfunction

    function automatic logic [11:0] enc(input int cls);
        logic [5:0] fn;
        fn = 6'($urandom);
        case (cls)
            C_ADDU:   return {6'b000000, 6'b100001};
            C_SUBU:   return {6'b000000, 6'b100011};
            C_ORI:    return {6'b001101, fn};
            C_LUI:    return {6'b001111, fn};
            C_LW:     return {6'b100011, fn};
            C_SW:     return {6'b101011, fn};
            C_BEQ:    return {6'b000100, fn};
            C_J:      return {6'b000010, fn};
            C_JAL:    return {6'b000011, fn};
            C_JR:     return {6'b000000, 6'b001000};
            C_NOP:    return {6'b000000, 6'b000000};
            C_ILL_OP: return {6'b111111, fn};
            default:  return {6'b000000, 6'b100000};
        endcase
    endfunction

    // {alu_src, ext_op, alu_op}
    function automatic logic [5:0] alu_of(input int cls);
        case (cls)
            C_SUBU, C_BEQ: return {1'b0, 2'b00, 3'b001};
            C_ORI:         return {1'b1, 2'b00, 3'b010};
            C_LUI:         return {1'b1, 2'b10, 3'b011};
            C_LW, C_SW:    return {1'b1, 2'b01, 3'b000};
            default:       return 6'b000000;
        endcase
    endfunction

    // {reg_dst, wd_sel, PCsel} during WB
    function automatic logic [5:0] wb_of(input int cls);
        case (cls)
            C_ADDU, C_SUBU: return {2'b01, 2'b00, 2'b00};
            C_LW:           return {2'b00, 2'b01, 2'b00};
            C_JAL:          return {2'b10, 2'b10, 2'b10};
            default:        return 6'b000000;
        endcase
    endfunction

    task automatic step(input string tag, input vec_t e, input logic ia, input logic da);
        imem_ack = ia;
        dmem_ack = da;
        #1;
        check(tag, 32'(obs), 32'(e));
        if (e.st != ST_TRAP) m_cyc++;
        if (e.pcwe) m_ret++;
        @(negedge clk);
    endtask

`ifdef MCTRL_PERF_CNT_EN
    task automatic check_counters(input string tag);
        check({tag, "_cyc"}, 32'(cyc_cnt), 32'(m_cyc % (1 << CNT_W)));
        check({tag, "_ret"}, 32'(ret_cnt), 32'(m_ret % (1 << CNT_W)));
    endtask
`endif

    task automatic trap_steps(input int n);
        vec_t e;
        e = at(ST_TRAP);
        e.tr = 1'b1;
        for (int i = 0; i < n; i++) step("trap_sticky", e, 1'($urandom), 1'($urandom));
`ifdef MCTRL_PERF_CNT_EN
        check_counters("perf_trap");
`endif
    endtask

    task automatic reset_pulse(input int ncyc);
        reset = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            imem_ack = 1'($urandom);
            dmem_ack = 1'($urandom);
            #1;
            check("reset_outputs", 32'(obs), 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    task automatic run_instr(input int cls, input int fw, input int mw);
        vec_t       e;
        logic [5:0] alu;
        logic [5:0] wb;
        {opcode, funct} = enc(cls);
        alu = alu_of(cls);
        wb  = wb_of(cls);
`ifdef MCTRL_PERF_CNT_EN
        check_counters("perf_start");
`endif
        e = at(ST_FETCH);
        e.ireq = 1'b1;
        for (int i = 0; i < fw && i < WAIT_LIMIT; i++) step("fetch_wait", e, 1'b0, 1'b0);
        if (fw >= WAIT_LIMIT) begin
            trap_steps(3);
            return;
        end
        e.irwe = 1'b1;
        step("fetch_ack", e, 1'b1, 1'b0);
        e = at(ST_DECODE);
        case (cls)
            C_J, C_JR, C_NOP: begin
                e.pcwe = 1'b1;
                e.pcs  = (cls == C_J) ? 2'b10 : (cls == C_JR) ? 2'b11 : 2'b00;
                step("decode_jump", e, 1'b0, 1'b0);
                return;
            end
            C_ILL_OP, C_ILL_FN: begin
                step("decode_ill", e, 1'b0, 1'b0);
                trap_steps(4);
                return;
            end
            default: step("decode", e, 1'b0, 1'b0);
        endcase
        if (cls != C_JAL) begin
            e = at(ST_EXEC);
            e.alu = alu;
            if (cls == C_BEQ) begin
                e.pcwe = 1'b1;
                e.pcs  = 2'b01;
                step("exec_beq", e, 1'b0, 1'b0);
                return;
            end
            step("exec", e, 1'b0, 1'b0);
        end
        if (cls == C_LW || cls == C_SW) begin
            e = at(ST_MEM);
            e.alu = alu;
            e.mre = (cls == C_LW);
            e.mwe = (cls == C_SW);
            for (int i = 0; i < mw && i < WAIT_LIMIT; i++) step("mem_wait", e, 1'b0, 1'b0);
            if (mw >= WAIT_LIMIT) begin
                trap_steps(3);
                return;
            end
            if (cls == C_SW) begin
                e.pcwe = 1'b1;
                step("mem_ack_sw", e, 1'b0, 1'b1);
                return;
            end
            step("mem_ack_lw", e, 1'b0, 1'b1);
        end
        e = at(ST_WB);
        e.alu  = alu;
        e.rwe  = 1'b1;
        e.pcwe = 1'b1;
        e.rd   = wb[5:4];
        e.wd   = wb[3:2];
        e.pcs  = wb[1:0];
        step("wb", e, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t e;
        int   cls, fw, mw;
        reset = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        opcode = 6'd0;
        funct = 6'd0;
        @(negedge clk);
        reset_pulse(3);

        run_instr(C_ADDU, 0, 0);
        run_instr(C_LW, 0, 3);
        run_instr(C_BEQ, 0, 0);
        run_instr(C_J, 0, 0);
        run_instr(C_JAL, 0, 0);
        run_instr(C_JR, 0, 0);
        run_instr(C_NOP, 0, 0);
        run_instr(C_SUBU, 0, 0);
        run_instr(C_ORI, 1, 0);
        run_instr(C_LUI, 0, 0);
        run_instr(C_SW, 0, 0);
        run_instr(C_SW, 2, 1);
        run_instr(C_ADDU, WAIT_LIMIT - 1, 0);
        run_instr(C_LW, 0, WAIT_LIMIT - 1);

        reset_pulse(1);
        run_instr(C_ADDU, 0, 0);
        run_instr(C_BEQ, 0, 0);
        run_instr(C_J, 0, 0);
`ifdef MCTRL_PERF_CNT_EN
        check("perf_ret3", 32'(ret_cnt), 32'd3);
        check("perf_cyc9", 32'(cyc_cnt), 32'd9);
`endif

        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 10);
            fw  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 2);
            mw  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAIT_LIMIT - 1) : $urandom_range(0, 2);
            run_instr(cls, fw, mw);
        end

        run_instr(C_ILL_OP, 0, 0);
        reset_pulse(1);
        run_instr(C_ILL_FN, 1, 0);
        reset_pulse(1);
        run_instr(C_ADDU, WAIT_LIMIT, 0);
        reset_pulse(1);
        run_instr(C_LW, 0, WAIT_LIMIT);
        reset_pulse(1);

        {opcode, funct} = enc(C_SW);
        e = at(ST_FETCH);
        e.ireq = 1'b1;
        e.irwe = 1'b1;
        step("rst_sw_fetch", e, 1'b1, 1'b0);
        step("rst_sw_decode", at(ST_DECODE), 1'b0, 1'b0);
        e = at(ST_EXEC);
        e.alu = alu_of(C_SW);
        step("rst_sw_exec", e, 1'b0, 1'b0);
        e = at(ST_MEM);
        e.alu = alu_of(C_SW);
        e.mwe = 1'b1;
        step("rst_sw_mem", e, 1'b0, 1'b0);
        step("rst_sw_mem", e, 1'b0, 1'b0);
        reset_pulse(2);
        run_instr(C_ADDU, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
